// File: rtl/dl_router_pkg.sv
// Shared types and constants for the download router.
package dl_router_pkg;

  localparam int unsigned ADDR_W    = 25;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CSUM_W    = 16;
  localparam int unsigned MAX_PORTS = 4;

  localparam logic [7:0] INDEX_ROM = 8'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/dl_reset_gen.sv
// Core reset stretcher: holds core_reset until the ROM is loaded and RESET_HOLD
// quiet cycles have elapsed since the last reset request.
module dl_reset_gen
  import dl_router_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_HOLD = 16'hFFFF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ext_reset,
  input  logic rom_loaded,
  output logic core_reset
);

  logic [CNT_W-1:0] count;

  // A pending request reloads the counter even when it is about to expire.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count      <= RESET_HOLD;
      core_reset <= 1'b1;
    end else begin
      if (ext_reset || !rom_loaded) begin
        count <= RESET_HOLD;
      end else if (count != '0) begin
        count <= count - CNT_W'(1);
      end
      core_reset <= (count != '0);
    end
  end

endmodule

// File: rtl/dl_router.sv
// Download router: steers ioctl ROM bytes to toggle-handshake SDRAM write ports,
// captures DIP bytes and drives the core reset. DL_ROUTER_CHECKSUM_EN adds a checksum output.
module dl_router
  import dl_router_pkg::*;
#(
  parameter int unsigned                 NUM_PORTS   = 2,
  parameter logic [NUM_PORTS*ADDR_W-1:0] REGION_BASE = {25'h10000, 25'h0},
  parameter int unsigned                 DIP_BYTES   = 8,
  parameter logic [7:0]                  DIP_INDEX   = 8'd254,
  parameter logic [CNT_W-1:0]            RESET_HOLD  = 16'hFFFF
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [DATA_W-1:0]      ioctl_dout,
  input  logic [7:0]             ioctl_index,
  input  logic                   ext_reset,
  output logic [NUM_PORTS-1:0]   port_req,
  input  logic [NUM_PORTS-1:0]   port_ack,
  output logic [ADDR_W-1:0]      port_addr,
  output logic [DATA_W-1:0]      port_data,
  output logic                   busy,
  output logic                   overrun,
  output logic                   rom_loaded,
  output logic                   core_reset,
`ifdef DL_ROUTER_CHECKSUM_EN
  output logic [DIP_BYTES*8-1:0] dip_sw,
  output logic [CSUM_W-1:0]      checksum
`else
  output logic [DIP_BYTES*8-1:0] dip_sw
`endif
);

  if (NUM_PORTS == 0 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("dl_router: NUM_PORTS out of range");
  end

  state_t                 state, state_d;
  logic                   wr_q, dl_q;
  logic                   strobe, dl_rise, dl_fall;
  logic [NUM_PORTS-1:0]   sel, sel_d, req_d, hit_mask;
  logic                   hit, ack_done;
  logic [ADDR_W-1:0]      offset;
  wr_beat_t               beat, beat_d;
  logic                   busy_d, overrun_d, rom_loaded_d, rom_pend, rom_pend_d;
  logic [DIP_BYTES*8-1:0] dip_d;
`ifdef DL_ROUTER_CHECKSUM_EN
  logic [CSUM_W-1:0]      csum_d;
`endif

  assign strobe    = ioctl_wr & ~wr_q;
  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign ack_done  = ((port_ack ^ port_req) & sel) == '0;
  assign port_addr = beat.addr;
  assign port_data = beat.data;

  // Region decode: the last (highest) base not above the address wins.
  always_comb begin
    hit      = 1'b0;
    hit_mask = '0;
    offset   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ioctl_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        hit_mask = NUM_PORTS'(1) << i;
        offset   = ioctl_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d      = state;
    req_d        = port_req;
    sel_d        = sel;
    beat_d       = beat;
    busy_d       = busy;
    overrun_d    = overrun;
    rom_loaded_d = rom_loaded;
    rom_pend_d   = rom_pend;
    dip_d        = dip_sw;
`ifdef DL_ROUTER_CHECKSUM_EN
    csum_d       = checksum;
    if (dl_rise) csum_d = '0;
`endif
    if (dl_rise) overrun_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (dl_fall && ioctl_index == INDEX_ROM) rom_loaded_d = 1'b1;
        if (strobe && ioctl_download) begin
          if (ioctl_index == INDEX_ROM && hit) begin
            state_d     = WAIT_ACK;
            sel_d       = hit_mask;
            req_d       = port_req ^ hit_mask;
            beat_d.addr = offset;
            beat_d.data = ioctl_dout;
            busy_d      = 1'b1;
`ifdef DL_ROUTER_CHECKSUM_EN
            csum_d      = csum_d + CSUM_W'(ioctl_dout);
`endif
          end else if (ioctl_index == DIP_INDEX && ioctl_addr < ADDR_W'(DIP_BYTES)) begin
            for (int unsigned k = 0; k < DIP_BYTES; k++) begin
              if (ioctl_addr[2:0] == 3'(k)) dip_d[k*8 +: 8] = ioctl_dout;
            end
          end
        end
      end
      WAIT_ACK: begin
        // A ROM download ending mid-request is only reported once the last byte lands.
        if (dl_fall && ioctl_index == INDEX_ROM) rom_pend_d = 1'b1;
        if (strobe && ioctl_download) overrun_d = 1'b1;
        if (ack_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (rom_pend_d) begin
            rom_loaded_d = 1'b1;
            rom_pend_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      port_req   <= '0;
      sel        <= '0;
      beat       <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      rom_loaded <= 1'b0;
      rom_pend   <= 1'b0;
      dip_sw     <= '0;
`ifdef DL_ROUTER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_d;
      wr_q       <= ioctl_wr;
      dl_q       <= ioctl_download;
      port_req   <= req_d;
      sel        <= sel_d;
      beat       <= beat_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
      rom_loaded <= rom_loaded_d;
      rom_pend   <= rom_pend_d;
      dip_sw     <= dip_d;
`ifdef DL_ROUTER_CHECKSUM_EN
      checksum   <= csum_d;
`endif
    end
  end

  dl_reset_gen #(
    .RESET_HOLD (RESET_HOLD)
  ) u_reset_gen (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ext_reset  (ext_reset),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset)
  );

endmodule

// File: tb/tb_dl_router.sv
// Scoreboard bench for dl_router: stimulus predicts port writes into a queue,
// a monitor pops and compares each port_req toggle; a responder models the SDRAM ports.
`timescale 1ns/1ps
module tb_dl_router;

  localparam int unsigned NP    = 3;
  localparam logic [15:0] HOLD  = 16'd20;
  localparam logic [7:0]  DIPIX = 8'd254;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download, ioctl_wr, ext_reset;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_index;
  logic [NP-1:0] port_req, port_ack;
  logic [24:0]   port_addr;
  logic [7:0]    port_data;
  logic          busy, overrun, rom_loaded, core_reset;
  logic [63:0]   dip_sw;
`ifdef DL_ROUTER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  dl_router #(
    .NUM_PORTS   (NP),
    .REGION_BASE ({25'h100000, 25'h10000, 25'h400}),
    .DIP_BYTES   (8),
    .DIP_INDEX   (DIPIX),
    .RESET_HOLD  (HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ext_reset      (ext_reset),
    .port_req       (port_req),
    .port_ack       (port_ack),
    .port_addr      (port_addr),
    .port_data      (port_data),
    .busy           (busy),
    .overrun        (overrun),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
`ifdef DL_ROUTER_CHECKSUM_EN
    .dip_sw         (dip_sw),
    .checksum       (checksum)
`else
    .dip_sw         (dip_sw)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [24:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  bit          have_last = 1'b0;
  logic [NP-1:0] prev_req = '0;
  logic [24:0] base_m [NP] = '{25'h400, 25'h10000, 25'h100000};
  logic [63:0] dip_m    = '0;
  logic [15:0] csum_m   = '0;
  logic        overrun_m = 1'b0;
  int          n_acc = 0, acks = 0, ack_cyc = 0, ack_cnt = 0, ack_delay = 0;
  logic        hold_ack = 1'b0;
  int          total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model of one strobe: decide from the address map what the ports must see.
  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                        input bit in_flight);
    int   p;
    exp_t e;
    @(posedge clk_sys); #1;
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    if (ioctl_download) begin
      if (in_flight) overrun_m = 1'b1;
      else if (idx == 8'd0) begin
        p = -1;
        for (int i = 0; i < NP; i++) if (a >= base_m[i]) p = i;
        if (p >= 0) begin
          e.port = p; e.addr = a - base_m[p]; e.data = d; e.cyc = cyc + 1;
          q.push_back(e);
          n_acc++;
          csum_m = csum_m + 16'(d);
        end
      end else if (idx == DIPIX && a < 25'd8) begin
        dip_m[a[2:0]*8 +: 8] = d;
      end
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || acks != n_acc) && t < 60) begin
      @(posedge clk_sys); t++;
    end
    total++;
    if (t >= 60) begin
      bad++;
      $display("FAIL idle_timeout act=%0d acks exp=%0d", acks, n_acc);
    end
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input int a0);
    int t = 0;
    while (acks == a0 && t < 50) begin
      @(negedge clk_sys); t++;
    end
    total++;
    if (acks == a0) begin
      bad++;
      $display("FAIL ack_timeout act=%0d exp=%0d", acks, a0 + 1);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_sys);
  endtask

  // Downstream port model: answers each toggle after ack_delay cycles unless held.
  initial begin
    port_ack = '0;
    forever begin
      @(posedge clk_sys); #2;
      if (!reset_n) begin
        port_ack = '0; ack_cnt = 0;
      end else if (!hold_ack && port_req !== port_ack) begin
        if (ack_cnt >= ack_delay) begin
          port_ack = port_req; acks++; ack_cyc = cyc; ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  // Monitor: every port_req toggle must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_req = port_req; q.delete(); have_last = 1'b0;
      end else if (port_req !== prev_req) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req act=%b exp=%b", port_req, prev_req);
        end else begin
          e = q.pop_front();
          chk("req_toggle", 64'(port_req ^ prev_req), 64'(1) << e.port);
          chk("port_addr", 64'(port_addr), 64'(e.addr));
          chk("port_data", 64'(port_data), 64'(e.data));
          chk("req_latency", 64'(cyc), 64'(e.cyc));
          last = e; have_last = 1'b1;
        end
        prev_req = port_req;
      end else if (busy && have_last) begin
        chk("addr_hold", 64'(port_addr), 64'(last.addr));
        chk("data_hold", 64'(port_data), 64'(last.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r, e_c, f_c, rc, k;
    logic [7:0]  idx;
    logic [24:0] a;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ext_reset = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;

    #12;
    chk("rst_port_req", 64'(port_req), 64'(0));
    chk("rst_port_addr", 64'(port_addr), 64'(0));
    chk("rst_port_data", 64'(port_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_rom_loaded", 64'(rom_loaded), 64'(0));
    chk("rst_dip", dip_sw, 64'(0));
    chk("rst_core_reset", 64'(core_reset), 64'(1));
    @(posedge clk_sys); #1 reset_n = 1'b1;
    @(posedge clk_sys); #1 ioctl_download = 1'b1;

    // Single write with a 3-cycle ack: busy must drop one cycle after the ack.
    ack_delay = 3; a0 = acks;
    strobe(8'd0, 25'h12345, 8'hA5, 1'b0);
    wait_ack(a0);
    chk("busy_at_ack", 64'(busy), 64'(1));
    @(negedge clk_sys);
    chk("busy_after_ack", 64'(busy), 64'(0));
    wait_idle();

    // Second strobe while the first is outstanding is dropped and flagged.
    hold_ack = 1'b1;
    strobe(8'd0, 25'h10010, 8'h3C, 1'b0);
    strobe(8'd0, 25'h10020, 8'h7E, 1'b1);
    repeat (3) @(negedge clk_sys);
    chk("overrun_set", 64'(overrun), 64'(overrun_m));
    chk("data_kept", 64'(port_data), 64'(8'h3C));
    chk("busy_held", 64'(busy), 64'(1));
    hold_ack = 1'b0;
    wait_idle();
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // DIP capture, out-of-range address ignored.
    for (int i = 0; i < 8; i++) strobe(DIPIX, 25'(i), 8'(8'h11 * (i + 1)), 1'b0);
    strobe(DIPIX, 25'd9, 8'h99, 1'b0);
    repeat (2) @(negedge clk_sys);
    chk("dip_sw", dip_sw, 64'h8877665544332211);
    chk("dip_model", dip_sw, dip_m);

    // Writes outside a download are ignored; a new download clears overrun.
    @(posedge clk_sys); #1 ioctl_index = 8'd5; ioctl_download = 1'b0;
    strobe(8'd0, 25'h12000, 8'h55, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("rom_not_loaded", 64'(rom_loaded), 64'(0));
    @(posedge clk_sys); #1 ioctl_download = 1'b1; overrun_m = 1'b0; csum_m = '0;
    repeat (2) @(negedge clk_sys);
    chk("overrun_cleared", 64'(overrun), 64'(overrun_m));
    ack_delay = 1;
    strobe(8'd0, 25'h401, 8'h01, 1'b0);    wait_idle();
    strobe(8'd0, 25'h10000, 8'hFF, 1'b0);  wait_idle();
    strobe(8'd0, 25'h100000, 8'h02, 1'b0); wait_idle();
`ifdef DL_ROUTER_CHECKSUM_EN
    chk("checksum_0102", 64'(checksum), 64'(16'h0102));
`endif

    // Randomised traffic across regions, boundaries, DIP and foreign indices.
    for (int n = 0; n < 60; n++) begin
      ack_delay = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 9));
      idx = (r < 6) ? 8'd0 : (r < 8) ? DIPIX : 8'd7;
      k = int'($urandom_range(0, 3));
      if (idx == DIPIX) a = 25'($urandom_range(0, 15));
      else if (k == 0) a = 25'($urandom_range(0, 32'h3FF));
      else if ($urandom_range(0, 3) == 0) a = base_m[k-1] - 25'd1;
      else a = base_m[k-1] + 25'($urandom_range(0, 32'hFF));
      strobe(idx, a, 8'($urandom), 1'b0);
      wait_idle();
    end
    chk("rand_dip", dip_sw, dip_m);
    chk("rand_overrun", 64'(overrun), 64'(overrun_m));
    chk("rand_core_reset", 64'(core_reset), 64'(1));
`ifdef DL_ROUTER_CHECKSUM_EN
    chk("rand_checksum", 64'(checksum), 64'(csum_m));
`endif

    // ROM download ends while a request is pending.
    hold_ack = 1'b1; ack_delay = 0;
    strobe(8'd0, 25'h10100, 8'hC3, 1'b0);
    @(posedge clk_sys); #1 ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("rom_wait_ack", 64'(rom_loaded), 64'(0));
    a0 = acks;
    hold_ack = 1'b0;
    wait_ack(a0);
    chk("rom_at_ack", 64'(rom_loaded), 64'(0));
    rc = ack_cyc + 1;
    wait_cyc(rc);
    chk("rom_after_ack", 64'(rom_loaded), 64'(1));
    wait_cyc(rc + int'(HOLD));
    chk("core_reset_hold", 64'(core_reset), 64'(1));
    wait_cyc(rc + int'(HOLD) + 1);
    chk("core_reset_fall", 64'(core_reset), 64'(0));

    // External reset pulse restarts the hold.
    @(posedge clk_sys); #1 ext_reset = 1'b1; e_c = cyc;
    @(posedge clk_sys); #1 ext_reset = 1'b0;
    wait_cyc(e_c + 2);
    chk("ext_rst_rise", 64'(core_reset), 64'(1));
    wait_cyc(e_c + int'(HOLD) + 1);
    chk("ext_rst_hold", 64'(core_reset), 64'(1));
    wait_cyc(e_c + int'(HOLD) + 2);
    chk("ext_rst_fall", 64'(core_reset), 64'(0));

    // Request arriving as the count reaches 1 must reload rather than expire.
    @(posedge clk_sys); #1 ext_reset = 1'b1; e_c = cyc;
    @(posedge clk_sys); #1 ext_reset = 1'b0;
    wait_cyc(e_c + int'(HOLD) - 1);
    @(posedge clk_sys); #1 ext_reset = 1'b1; f_c = cyc;
    @(posedge clk_sys); #1 ext_reset = 1'b0;
    wait_cyc(f_c + 2);
    chk("load_wins", 64'(core_reset), 64'(1));
    wait_cyc(f_c + int'(HOLD) + 1);
    chk("load_wins_hold", 64'(core_reset), 64'(1));
    wait_cyc(f_c + int'(HOLD) + 2);
    chk("load_wins_fall", 64'(core_reset), 64'(0));

    // Asynchronous reset in the middle of a request.
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    hold_ack = 1'b1;
    strobe(8'd0, 25'h100123, 8'h5A, 1'b0);
    @(posedge clk_sys); #3 reset_n = 1'b0;
    #1;
    chk("ar_port_req", 64'(port_req), 64'(0));
    chk("ar_port_addr", 64'(port_addr), 64'(0));
    chk("ar_port_data", 64'(port_data), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_overrun", 64'(overrun), 64'(0));
    chk("ar_rom_loaded", 64'(rom_loaded), 64'(0));
    chk("ar_dip", dip_sw, 64'(0));
    chk("ar_core_reset", 64'(core_reset), 64'(1));
`ifdef DL_ROUTER_CHECKSUM_EN
    chk("ar_checksum", 64'(checksum), 64'(0));
`endif
    hold_ack = 1'b0; ioctl_download = 1'b0;
    dip_m = '0; csum_m = '0; overrun_m = 1'b0;
    #20;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    n_acc = acks;
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    strobe(8'd0, 25'h10002, 8'h01, 1'b0);
    wait_idle();
    strobe(8'd0, 25'h3FF, 8'h44, 1'b0);
    wait_idle();
`ifdef DL_ROUTER_CHECKSUM_EN
    chk("post_rst_checksum", 64'(checksum), 64'(csum_m));
`endif
    chk("post_rst_overrun", 64'(overrun), 64'(overrun_m));
    chk("post_rst_queue", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dl_router.md
DL_ROUTER -- requirements
Module: dl_router

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of downstream SDRAM write ports, 1..4.
REQ-002 Parameter REGION_BASE, default {25'h10000, 25'h0} (packed, NUM_PORTS x 25, entry 0 in LSBs): first byte address owned by each port, strictly ascending.
REQ-003 Parameter DIP_BYTES, default 8: DIP switch bytes captured, 1..8.
REQ-004 Parameter DIP_INDEX, default 254: ioctl_index value that selects DIP data.
REQ-005 Parameter RESET_HOLD, default 16'hFFFF: core_reset hold length in clk_sys cycles.
REQ-006 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 ioctl_download  in  1  download window active.
REQ-009 ioctl_wr  in  1  byte strobe; a write is its 0->1 transition.
REQ-010 ioctl_addr  in  25  byte address.
REQ-011 ioctl_dout  in  8  byte data.
REQ-012 ioctl_index  in  8  download type; 0 = ROM, DIP_INDEX = DIP.
REQ-013 ext_reset  in  1  user/system reset request, active high.
REQ-014 port_req  out  NUM_PORTS  toggle-request per port.
REQ-015 port_ack  in  NUM_PORTS  toggle-acknowledge; request complete when port_ack[i]==port_req[i].
REQ-016 port_addr  out  25  byte offset within the selected region.
REQ-017 port_data  out  8  byte to write.
REQ-018 busy  out  1  a request is outstanding.
REQ-019 overrun  out  1  sticky: a write strobe arrived while busy.
REQ-020 rom_loaded  out  1  sticky: one complete ROM download has finished.
REQ-021 core_reset  out  1  active-high reset for the game core.
REQ-022 dip_sw  out  DIP_BYTES*8  captured DIP bytes, byte k at [8k+7:8k].

Function
REQ-023 Index-0 write: port = highest i with ioctl_addr >= REGION_BASE[i]; port_addr = ioctl_addr - REGION_BASE[i] (25-bit, no wrap); addresses below REGION_BASE[0] are dropped silently.
REQ-024 FSM states IDLE, WAIT_ACK; IDLE->WAIT_ACK on accepted write, WAIT_ACK->IDLE in the cycle after port_ack[i]==port_req[i] is sampled.
REQ-025 Strobe edge sampled in cycle N: port_addr, port_data, port_req[i] toggle and busy=1 visible at N+1; port_addr/port_data held stable until IDLE.
REQ-026 Strobe edge in WAIT_ACK: byte discarded, overrun set; overrun cleared only by reset_n or a new download start (ioctl_download 0->1).
REQ-027 Writes with ioctl_download=0 are ignored.
REQ-028 DIP write (index==DIP_INDEX, ioctl_addr < DIP_BYTES): dip_sw byte ioctl_addr[2:0] updated at N+1; no port request; larger addresses ignored.
REQ-029 rom_loaded sets when ioctl_download falls with ioctl_index==0 and FSM in IDLE; if falling edge occurs in WAIT_ACK, set on return to IDLE.
REQ-030 Reset counter loads RESET_HOLD while ext_reset=1 or rom_loaded=0, else decrements to 0 and holds; core_reset = (counter!=0), registered.
REQ-031 Simultaneous ext_reset and counter==1: load wins.

Reset
REQ-032 reset_n low: port_req=0, port_addr=0, port_data=0, busy=0, overrun=0, rom_loaded=0, dip_sw=0, counter=RESET_HOLD, core_reset=1, FSM=IDLE, edge detector=0.
REQ-033 reset_n asserted mid-request abandons it; downstream must be reset together (port_ack returns to 0).

Configuration
REQ-034 DL_ROUTER_CHECKSUM_EN defined: adds output checksum[15:0], 16-bit wrapping sum of every accepted index-0 byte, cleared at download start and by reset_n.
REQ-035 DL_ROUTER_CHECKSUM_EN undefined: no checksum port and no adder.

Structure
REQ-036 Package dl_router_pkg holds the FSM state typedef, INDEX_ROM=8'd0, and MAX_PORTS=4.
REQ-037 One sub-module, dl_reset_gen, holds the reset counter (REQ-030/031).

Verification
REQ-038 Write 0x00012345 = 8'hA5, ack after 3 cycles: port_req[1] toggles at N+1, port_addr=0x2345, port_data=A5, busy low 1 cycle after ack.
REQ-039 Second strobe 2 cycles after the first, ack withheld: overrun=1, only one port_req toggle, first data unchanged.
REQ-040 Index 254 at addr 0..7 with 0x11..0x88: dip_sw=64'h8877665544332211; addr 9 has no effect; port_req unchanged.
REQ-041 Download ends in WAIT_ACK: rom_loaded rises only after ack; core_reset falls RESET_HOLD+1 cycles after rom_loaded.
REQ-042 reset_n pulsed low mid-request: all outputs at REQ-032 values asynchronously; checksum (when enabled) of 0x01,0xFF,0x02 = 16'h0102.
